exotiny_wb_conout: RTL and testbench

Synthesizable Wishbone-classic slave console port for the ExoTiny SoC. It accepts character writes from the CPU data bus, buffers them in a small FIFO, and serializes them on an 8N1 UART TX pin. It also detects the "DONE" and "ERR" test-termination signatures in hardware and exposes them as sticky flags. This moves end-of-test detection into silicon for FPGA and ASIC runs.

---
 rtl/exotiny_wb_conout.sv | 259 +++++++++++++++++++++++++
 tb/tb_exotiny_wb_conout.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exotiny_wb_conout.sv
// ============================================================================
// exotiny_wb_conout
// ----------------------------------------------------------------------------
// Wishbone-classic slave console port for the ExoTiny SoC.
//
// The CPU writes characters to the DATA register. They are buffered in a small
// circular FIFO and shifted out on an 8N1 UART transmit line. Every accepted
// DATA write is also shifted into a 32-bit signature register, so the block
// recognises the "DONE" and "ERR" end-of-test strings on its own and raises
// sticky flags that FPGA/ASIC harnesses can watch directly.
//
// Bus handshake (valid/ready in Wishbone-classic terms):
//   A cycle is "accepted" when wb_stb_i=1 and wb_ack_o=0, unless it is a DATA
//   write and the FIFO is full (then the slave inserts wait states). The
//   acknowledge is registered: wb_ack_o is high for exactly the one cycle
//   after the accept, and wb_dat_o carries the read data in that same cycle.
//   Because an accept needs wb_ack_o=0, two acks are never back to back.
//
// Register map (wb_adr_i):
//   0 DATA   write: push wb_dat_i[7:0] into the TX FIFO; read: 0
//   1 STATUS read : {27'b0, err, done, fifo_empty, fifo_full, tx_busy}
//            write: wb_dat_i[0]=1 clears done, err and the signature register
//
// Ports:
//   clk_i      system clock
//   rst_in     asynchronous active-low reset
//   wb_stb_i   strobe, held by the master until ack
//   wb_we_i    write enable
//   wb_adr_i   register select (0 = DATA, 1 = STATUS)
//   wb_dat_i   write data
//   wb_dat_o   read data, valid while wb_ack_o
//   wb_ack_o   one-cycle acknowledge
//   tx_o       UART transmit line, idle high
//   done_o     sticky "DONE" seen
//   err_o      sticky "ERR" seen
//
// Parameters:
//   CLKDIV     clock cycles per UART bit (>= 2)
//   FIFODEPTH  TX FIFO entries (power of 2, >= 2)
// ============================================================================
module exotiny_wb_conout #(
    parameter int CLKDIV    = 104,
    parameter int FIFODEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic        wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        tx_o,
    output logic        done_o,
    output logic        err_o
);

    // ------------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------------
    localparam int AW = $clog2(FIFODEPTH);   // FIFO index width
    localparam int CW = $clog2(CLKDIV);      // baud counter width

    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] BAUD_ONE    = CW'(1);
    localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);

    localparam logic [31:0] SIG_DONE = 32'h444F_4E45;  // "DONE"
    localparam logic [23:0] SIG_ERR  = 24'h45_5252;    // "ERR"

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    // FIFO storage and pointers. The pointers carry one extra MSB so that
    // "full" (same index, different lap) and "empty" (identical) differ.
    logic [7:0]  fifo_mem [FIFODEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;

    // Bus-side decode
    logic        is_data_wr;
    logic        accept;
    logic        push;
    logic        sig_clear;
    logic [31:0] status_word;

    // Signature shift register
    logic [31:0] sig_sr;
    logic [31:0] sig_sr_next;

    // UART transmitter
    tx_state_t   tx_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_buf;
    logic        pop;
    logic        tx_busy;

    // Upper write-data bits are not used by any register.
    logic        unused_dat;
    assign unused_dat = ^wb_dat_i[31:8];

    // ------------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    assign is_data_wr = wb_we_i && !wb_adr_i;

    // A DATA write waits while the FIFO is full. "full" is a registered
    // condition, so a pop by the transmitter frees the slot one cycle later;
    // the push and the accept happen together in that following cycle.
    assign accept    = wb_stb_i && !wb_ack_o && !(is_data_wr && fifo_full);
    assign push      = accept && is_data_wr;
    assign sig_clear = accept && wb_we_i && wb_adr_i && wb_dat_i[0];

    assign tx_busy     = (tx_state != S_IDLE);
    assign status_word = {27'b0, err_o, done_o, fifo_empty, fifo_full, tx_busy};

    assign sig_sr_next = {sig_sr[23:0], wb_dat_i[7:0]};

    // ------------------------------------------------------------------------
    // Bus response, write pointer and signature detection
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'b0;
            wr_ptr   <= '0;
            sig_sr   <= 32'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            wb_ack_o <= accept;

            // Read data is only non-zero in the ack cycle of a STATUS read.
            if (accept && !wb_we_i && wb_adr_i) begin
                wb_dat_o <= status_word;
            end else begin
                wb_dat_o <= 32'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            // The match is taken on the value being shifted in, so the flag
            // rises together with the ack of the completing character.
            // A clear has priority over any simultaneous shift/match.
            if (sig_clear) begin
                sig_sr <= 32'b0;
                done_o <= 1'b0;
                err_o  <= 1'b0;
            end else if (push) begin
                sig_sr <= sig_sr_next;
                if (sig_sr_next == SIG_DONE) begin
                    done_o <= 1'b1;
                end
                if (sig_sr_next[23:0] == SIG_ERR) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    // FIFO storage has no reset: contents are only ever read behind rd_ptr,
    // which cannot pass wr_ptr.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // UART transmitter FSM (8N1, LSB first)
    // ------------------------------------------------------------------------
    // The FIFO is popped only from IDLE. After the last STOP cycle the FSM
    // spends one cycle in IDLE before the next START, giving a one-cycle gap
    // between back-to-back frames.
    assign pop = (tx_state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            tx_state  <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_buf <= 8'h00;
            rd_ptr    <= '0;
            tx_o      <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift_buf <= fifo_mem[rd_ptr[AW-1:0]];
                        rd_ptr    <= rd_ptr + PTR_ONE;
                        baud_cnt  <= BAUD_RELOAD;
                        tx_o      <= 1'b0;
                        tx_state  <= S_START;
                    end
                end

                S_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= 3'd0;
                        tx_o     <= shift_buf[0];
                        tx_state <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx_o     <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift_buf[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

                S_STOP: begin
                    if (baud_cnt == '0) begin
                        tx_state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end

                default: begin
                    tx_o     <= 1'b1;
                    tx_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exotiny_wb_conout.sv
// ============================================================================
// tb_exotiny_wb_conout
// ----------------------------------------------------------------------------
// Directed bench for exotiny_wb_conout with CLKDIV=4, FIFODEPTH=4.
// Inputs are driven on the falling clock edge, outputs sampled on the falling
// edge (half a cycle away from the active rising edge).
// ============================================================================
module tb_exotiny_wb_conout;

    localparam int CLKDIV    = 4;
    localparam int FIFODEPTH = 4;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb;
    logic        we;
    logic        adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        tx;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    exotiny_wb_conout #(
        .CLKDIV    (CLKDIV),
        .FIFODEPTH (FIFODEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_in   (rst_n),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .tx_o     (tx),
        .done_o   (done),
        .err_o    (err)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // An ack must never follow an ack.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (ack) begin
            check("ack_not_back_to_back", {31'b0, ack_prev}, 32'd0);
        end
        ack_prev = ack;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    // One Wishbone cycle. 'waits' is the number of falling edges from driving
    // the strobe up to and including the one where ack is seen (1 = no wait).
    task automatic xfer(input logic w, input logic a, input logic [31:0] d,
                        output logic [31:0] r, output int waits);
        @(negedge clk);
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!ack && waits < 300);
        check("ack_seen", {31'b0, ack}, 32'd1);
        r    = rdat;
        stb  = 1'b0;
        we   = 1'b0;
        wdat = 32'b0;
    endtask

    task automatic wr_data(input logic [7:0] b, output int waits);
        logic [31:0] r;
        xfer(1'b1, 1'b0, {24'b0, b}, r, waits);
    endtask

    task automatic rd_status(output logic [31:0] r);
        int waits;
        xfer(1'b0, 1'b1, 32'b0, r, waits);
    endtask

    // Poll STATUS until the transmitter is idle and the FIFO empty.
    task automatic wait_idle(input string tag);
        logic [31:0] r;
        int n = 0;
        do begin
            rd_status(r);
            n++;
        end while (r[2:0] !== 3'b100 && n < 200);
        check(tag, {29'b0, r[2:0]}, 32'h4);
    endtask

    // Wait for a start bit, then compare every cycle of the 10-bit frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        int n = 0;
        bits = {1'b1, b, 1'b0};
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10 * CLKDIV; i++) begin
            if (i > 0) @(negedge clk);
            check(tag, {31'b0, tx}, {31'b0, bits[i / CLKDIV]});
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] r;
        int          w;
        int          bp_waits [6];
        logic [7:0]  bp_bytes [6];

        rst_n = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 1'b0;
        wdat  = 32'b0;

        // ---- Reset ----
        repeat (5) @(negedge clk);
        check("rst_tx",   {31'b0, tx},   32'd1);
        check("rst_ack",  {31'b0, ack},  32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err",  {31'b0, err},  32'd0);
        check("rst_dat",  rdat,          32'd0);
        rst_n = 1'b1;

        rd_status(r);
        check("status_after_reset", r, 32'h4);
        xfer(1'b0, 1'b0, 32'b0, r, w);
        check("data_read_zero", r, 32'h0);

        // ---- Single character 'A' ----
        wr_data(8'h41, w);
        check("single_ack_latency", w, 1);
        @(negedge clk);
        check("single_tx_fall", {31'b0, tx}, 32'd0);
        check_frame(8'h41, "frame_41");
        @(negedge clk);
        rd_status(r);
        check("single_idle_status", r, 32'h4);

        // ---- Backpressure: six writes back to back ----
        bp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_data(bp_bytes[i], w);
                    bp_waits[i] = w;
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    check_frame(bp_bytes[i], $sformatf("bp_frame_%0d", i));
                end
            end
        join
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_prompt_ack_%0d", i), bp_waits[i], 1);
        end
        // Write 6 enters at the same edge write 5 is acked + 1; it is held
        // until the IDLE cycle after frame 1's stop bit pops, then accepted.
        check("bp_stall_ack", bp_waits[5], 34);
        wait_idle("bp_drained");

        // ---- DONE detection ----
        wr_data("D", w);
        wr_data("O", w);
        wr_data("N", w);
        check("done_before_E", {31'b0, done}, 32'd0);
        wr_data("E", w);
        check("done_after_E", {31'b0, done}, 32'd1);
        check("err_after_DONE", {31'b0, err}, 32'd0);
        rd_status(r);
        check("status_done_bit", {30'b0, r[4:3]}, 32'h1);

        // ---- ERR detection and clear ----
        wr_data("E", w);
        wr_data("R", w);
        check("err_before_last_R", {31'b0, err}, 32'd0);
        wr_data("R", w);
        check("err_after_ERR", {31'b0, err}, 32'd1);
        xfer(1'b1, 1'b1, 32'h0, r, w);
        check("err_kept_on_noclear", {31'b0, err}, 32'd1);
        check("done_kept_on_noclear", {31'b0, done}, 32'd1);
        xfer(1'b1, 1'b1, 32'h1, r, w);
        check("err_cleared", {31'b0, err}, 32'd0);
        check("done_cleared", {31'b0, done}, 32'd0);
        wr_data("R", w);
        check("err_not_reset_by_R", {31'b0, err}, 32'd0);
        rd_status(r);
        check("status_flags_clear", {30'b0, r[4:3]}, 32'h0);
        wait_idle("sig_drained");

        // ---- Reset in the middle of a frame ----
        wr_data(8'h00, w);
        wr_data(8'h66, w);
        wr_data(8'h77, w);
        repeat (4) @(negedge clk);
        check("mid_frame_tx_low", {31'b0, tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_tx_high", {31'b0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_status(r);
        check("status_after_mid_reset", r, 32'h4);
        wr_data(8'hA5, w);
        check_frame(8'hA5, "frame_after_reset");
        repeat (10) @(negedge clk);
        check("line_idle_after_reset", {31'b0, tx}, 32'd1);
        rd_status(r);
        check("no_stale_frames", r, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
